// File: rtl/exec_unit.sv
// Execute/write-back stage of the 8-bit toy CPU: owns R0..R3 and the PC,
// executes add/li/bner0, and exposes retire, write-back and debug ports.
module exec_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        opcode,
    input  logic [1:0]        rd,
    input  logic [1:0]        rs1,
    input  logic [1:0]        rs2,
    input  logic [3:0]        addr,
    input  logic [3:0]        imm,
    output logic [3:0]        pc,
    output logic              retire,
    output logic              wb_en,
    output logic [1:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_ILL   = 2'b01;
    localparam logic [1:0] OP_LI    = 2'b10;
    localparam logic [1:0] OP_BNER0 = 2'b11;

    logic [DATA_W-1:0] r_regs [4];
    logic [3:0]        r_pc;
    logic              r_retire;
    logic              r_wb_en;
    logic [1:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_illegal;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_taken;
    logic [3:0]        w_pc_inc;

    always_comb begin
        w_accept  = in_valid & ~r_halted;
        w_src1    = r_regs[rs1];
        w_src2    = r_regs[rs2];
        w_sum     = w_src1 + w_src2;
        w_imm_ext = DATA_W'(imm);
        // rs2 = 0 compares R0 with itself, so that form never branches
        w_taken   = (w_src2 != r_regs[0]);
        w_pc_inc  = r_pc + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
            r_pc      <= '0;
            r_retire  <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_retire <= 1'b0;
            r_wb_en  <= 1'b0;
            if (w_accept) begin
                r_retire <= 1'b1;
                r_cnt    <= r_cnt + 1'b1;
                case (opcode)
                    OP_ADD: begin
                        r_regs[rd] <= w_sum;
                        r_wb_en    <= 1'b1;
                        r_wb_rd    <= rd;
                        r_wb_data  <= w_sum;
                        r_pc       <= w_pc_inc;
                    end
                    OP_LI: begin
                        r_regs[rd] <= w_imm_ext;
                        r_wb_en    <= 1'b1;
                        r_wb_rd    <= rd;
                        r_wb_data  <= w_imm_ext;
                        r_pc       <= w_pc_inc;
                    end
                    OP_BNER0: begin
                        if (w_taken) begin
                            r_pc <= addr;
                            // a taken branch onto itself can never make progress
                            if (addr == r_pc) r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                    OP_ILL: begin
                        r_illegal <= 1'b1;
                        r_pc      <= w_pc_inc;
                    end
                    default: r_pc <= w_pc_inc;
                endcase
            end
        end
    end

    assign pc          = r_pc;
    assign retire      = r_retire;
    assign wb_en       = r_wb_en;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign illegal     = r_illegal;
    assign halted      = r_halted;
    assign retired_cnt = r_cnt;
    assign dbg_data    = r_regs[dbg_sel];

endmodule
